// File: rtl/cdc_serial_deserializer.sv
// -----------------------------------------------------------------------------
// cdc_serial_deserializer
//   Recovers words from a foreign serial link (TXClk/TXData/TXValid) that is
//   oversampled by the local RXClk. No phase or frequency relationship between
//   the two clocks is assumed. Bits are taken on synchronised falling TXClk
//   edges. They are assembled into WIDTH-bit words, either LSB first or MSB
//   first. Each word is offered on a valid/ready interface that has a
//   one-deep holding register.
//
// Parameters:
//   WIDTH        bits per word (2..64)
//   SYNC_STAGES  synchroniser depth per asynchronous input (2..4)
//   LSB_FIRST    1: first bit received -> RXWord[0]; 0: -> RXWord[WIDTH-1]
//
// Ports:
//   RXClk     in   local clock, all flops rising edge
//   Reset     in   asynchronous active-high reset
//   TXClk     in   foreign serial clock, sampled as data
//   TXData    in   serial data, changes on TXClk rise
//   TXValid   in   high while a word is being sent
//   RXWord    out  received word, held while RXValid && !RXReady
//   RXValid   out  word available
//   RXReady   in   consumer takes the word when RXValid && RXReady
//   Overflow  out  one-cycle pulse: a completed word was dropped
//   FrameErr  out  one-cycle pulse: a partial word was discarded
//   BitCount  out  bits collected so far in the current word
//   ErrCount  out  (only with CDC_DESER_ERRCNT_EN) saturating 8-bit count of
//                  Overflow + FrameErr pulses
//
// Optional feature macro: CDC_DESER_ERRCNT_EN
// -----------------------------------------------------------------------------
module cdc_serial_deserializer #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter bit LSB_FIRST   = 1'b1
) (
  input  logic                       RXClk,
  input  logic                       Reset,
  input  logic                       TXClk,
  input  logic                       TXData,
  input  logic                       TXValid,
  output logic [WIDTH-1:0]           RXWord,
  output logic                       RXValid,
  input  logic                       RXReady,
  output logic                       Overflow,
  output logic                       FrameErr,
  output logic [$clog2(WIDTH+1)-1:0] BitCount
`ifdef CDC_DESER_ERRCNT_EN
  ,
  output logic [7:0]                 ErrCount
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  // Three identical chains keep TXClk, TXData and TXValid aligned to each other.
  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] data_sync_r;
  logic [SYNC_STAGES-1:0] valid_sync_r;
  logic                   clk_prev_r;

  logic [WIDTH-1:0] sr_r;
  logic [WIDTH-1:0] sr_next_s;

  logic clk_s;
  logic data_s;
  logic valid_s;
  logic fall_s;
  logic shift_en_s;
  logic complete_s;
  logic frame_set_s;
  logic hold_free_s;
  logic load_s;
  logic ovf_set_s;

  assign clk_s   = clk_sync_r[SYNC_STAGES-1];
  assign data_s  = data_sync_r[SYNC_STAGES-1];
  assign valid_s = valid_sync_r[SYNC_STAGES-1];

  // Synchroniser chains plus the previous-TXClk flop used for edge detection.
  always_ff @(posedge RXClk or posedge Reset) begin
    if (Reset) begin
      clk_sync_r   <= {SYNC_STAGES{1'b0}};
      data_sync_r  <= {SYNC_STAGES{1'b0}};
      valid_sync_r <= {SYNC_STAGES{1'b0}};
      // Resetting to 0 means a TXClk held high through reset release
      // cannot produce a false fall.
      clk_prev_r   <= 1'b0;
    end else begin
      clk_sync_r   <= {clk_sync_r[SYNC_STAGES-2:0], TXClk};
      data_sync_r  <= {data_sync_r[SYNC_STAGES-2:0], TXData};
      valid_sync_r <= {valid_sync_r[SYNC_STAGES-2:0], TXValid};
      clk_prev_r   <= clk_s;
    end
  end

  // Edge detection, next shift value and word-completion decisions.
  always_comb begin
    fall_s      = clk_prev_r & ~clk_s;
    shift_en_s  = fall_s & valid_s;
    complete_s  = shift_en_s && (BitCount == CW'(WIDTH - 1));
    frame_set_s = fall_s && !valid_s && (BitCount != {CW{1'b0}});
    // The holding register is free if it is empty, or if it empties on this edge.
    hold_free_s = !RXValid || RXReady;
    load_s      = complete_s && hold_free_s;
    ovf_set_s   = complete_s && !hold_free_s;
    if (LSB_FIRST) begin
      sr_next_s = {data_s, sr_r[WIDTH-1:1]};
    end else begin
      sr_next_s = {sr_r[WIDTH-2:0], data_s};
    end
  end

  // Shift register and bit counter.
  always_ff @(posedge RXClk or posedge Reset) begin
    if (Reset) begin
      sr_r     <= {WIDTH{1'b0}};
      BitCount <= {CW{1'b0}};
    end else begin
      if (shift_en_s) begin
        sr_r <= sr_next_s;
      end else begin
        sr_r <= sr_r;
      end
      if (complete_s || frame_set_s) begin
        BitCount <= {CW{1'b0}};
      end else if (shift_en_s) begin
        BitCount <= BitCount + {{(CW-1){1'b0}}, 1'b1};
      end else begin
        BitCount <= BitCount;
      end
    end
  end

  // Holding register, handshake and error pulses. A completed word takes
  // priority over the handshake drop, so loads can run back to back.
  always_ff @(posedge RXClk or posedge Reset) begin
    if (Reset) begin
      RXWord   <= {WIDTH{1'b0}};
      RXValid  <= 1'b0;
      Overflow <= 1'b0;
      FrameErr <= 1'b0;
    end else begin
      if (load_s) begin
        RXWord  <= sr_next_s;
        RXValid <= 1'b1;
      end else if (RXValid && RXReady) begin
        RXWord  <= RXWord;
        RXValid <= 1'b0;
      end else begin
        RXWord  <= RXWord;
        RXValid <= RXValid;
      end
      Overflow <= ovf_set_s;
      FrameErr <= frame_set_s;
    end
  end

`ifdef CDC_DESER_ERRCNT_EN
  // Saturating error counter. Overflow and FrameErr never coincide, so the
  // counter steps by at most one per cycle.
  always_ff @(posedge RXClk or posedge Reset) begin
    if (Reset) begin
      ErrCount <= 8'h00;
    end else if ((ovf_set_s || frame_set_s) && (ErrCount != 8'hFF)) begin
      ErrCount <= ErrCount + 8'h01;
    end else begin
      ErrCount <= ErrCount;
    end
  end
`endif

endmodule
